// File: rtl/ppu_tile_fetch_pkg.sv
// Shared constants and FSM state type for the PPU background tile fetcher.
package ppu_pkg;

  localparam int X_START        = 64;
  localparam int V_LAST         = 524;
  localparam int NES_W          = 256;
  localparam int NES_H          = 240;
  localparam int TILES_PER_LINE = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NT,
    ST_LO,
    ST_HI,
    ST_WR
  } fetch_state_t;

endpackage

// File: rtl/ppu_line_buf.sv
// Double-banked background line store: 2 banks x 32 tiles x {hi_byte, lo_byte}.
// One synchronous write port (fetcher) and one asynchronous read port (display).
module ppu_line_buf
  import ppu_pkg::*;
(
  input  logic        CLK25,
  input  logic        we,
  input  logic        wbank,
  input  logic [4:0]  waddr,
  input  logic [15:0] wdata,
  input  logic        rbank,
  input  logic [4:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [2*TILES_PER_LINE];

  // Store one fetched tile row; contents survive reset.
  always_ff @(posedge CLK25) begin
    if (we) begin
      mem[{wbank, waddr}] <= wdata;
    end
  end

  assign rdata = mem[{rbank, raddr}];

endmodule

// File: rtl/ppu_tile_fetch.sv
// Background tile fetch scheduler: fetches one NES line ahead of display into
// a double-banked line store and returns the 2-bit pixel index for the beam.
module ppu_tile_fetch
  import ppu_pkg::*;
#(
  parameter int X_START = ppu_pkg::X_START,
  parameter int V_LAST  = ppu_pkg::V_LAST
) (
  input  logic        CLK25,
  input  logic        RST,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [10:0] vaddr,
  input  logic [7:0]  vdata,
  output logic [10:0] faddr,
  input  logic [7:0]  fdata,
  output logic [1:0]  pix,
  output logic        busy
);

  localparam logic [9:0] X_LO        = 10'(X_START);
  localparam logic [9:0] X_HI        = 10'(X_START + 2*NES_W);
  localparam logic [9:0] Y_VIS       = 10'(2*NES_H);
  localparam logic [9:0] Y_TRIG_LIM  = 10'(2*NES_H - 1);
  localparam logic [9:0] Y_WRAP      = 10'(V_LAST);
  localparam logic [4:0] C_LAST      = 5'(TILES_PER_LINE - 1);

  fetch_state_t state;
  logic [7:0]   t;
  logic [4:0]   c;
  logic [6:0]   tile;
  logic [7:0]   lo;

  logic         trig;
  logic [7:0]   trig_line;

  logic [9:0]   xo;
  logic [7:0]   px;
  logic         in_win;
  logic [15:0]  rd;
  logic [3:0]   idx_lo;
  logic [3:0]   idx_hi;

  logic         unused_bits;
  assign unused_bits = &{1'b0, xo[9], xo[0], vdata[7]};

  // Decode the fetch trigger at the start of each VGA line.
  always_comb begin
    trig      = 1'b0;
    trig_line = '0;
    if (x == '0) begin
      if ((y < Y_TRIG_LIM) && y[0]) begin
        trig      = 1'b1;
        trig_line = 8'(y[9:1]) + 8'd1;
      end else if (y == Y_WRAP) begin
        trig      = 1'b1;
        trig_line = '0;
      end
    end
  end

  // Fetch FSM: vaddr is loaded on entry to NT so the nametable byte is
  // present during LO; faddr is loaded at the end of LO/HI so each pattern
  // byte is present during the following state.
  always_ff @(posedge CLK25 or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      t     <= '0;
      c     <= '0;
      tile  <= '0;
      lo    <= '0;
      vaddr <= '0;
      faddr <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig) begin
            t     <= trig_line;
            c     <= '0;
            vaddr <= {1'b0, trig_line[7:3], 5'd0};
            busy  <= 1'b1;
            state <= ST_NT;
          end
        end
        ST_NT: begin
          state <= ST_LO;
        end
        ST_LO: begin
          tile  <= vdata[6:0];
          faddr <= {vdata[6:0], 1'b0, t[2:0]};
          state <= ST_HI;
        end
        ST_HI: begin
          lo    <= fdata;
          faddr <= {tile, 1'b1, t[2:0]};
          state <= ST_WR;
        end
        ST_WR: begin
          if (c == C_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            c     <= c + 5'd1;
            vaddr <= {1'b0, t[7:3], c + 5'd1};
            state <= ST_NT;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign xo     = x - X_LO;
  assign px     = xo[8:1];
  assign in_win = (x >= X_LO) && (x < X_HI) && (y < Y_VIS);
  assign idx_lo = {1'b0, ~px[2:0]};
  assign idx_hi = {1'b1, ~px[2:0]};

  ppu_line_buf u_line_buf (
    .CLK25 (CLK25),
    .we    (state == ST_WR),
    .wbank (t[0]),
    .waddr (c),
    .wdata ({fdata, lo}),
    .rbank (y[1]),
    .raddr (px[7:3]),
    .rdata (rd)
  );

  // Register the pixel index for the presented beam position.
  always_ff @(posedge CLK25 or posedge RST) begin
    if (RST) begin
      pix <= '0;
    end else if (in_win) begin
      pix <= {rd[idx_hi], rd[idx_lo]};
    end else begin
      pix <= '0;
    end
  end

endmodule

// File: tb/tb_ppu_tile_fetch.sv
// Self-checking bench for ppu_tile_fetch with a line-level reference model.
module tb_ppu_tile_fetch;

  localparam int XS = 64;
  localparam int VL = 524;

  logic        CLK25 = 1'b0;
  logic        RST   = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [10:0] vaddr;
  logic [10:0] faddr;
  logic [7:0]  vdata;
  logic [7:0]  fdata;
  logic [1:0]  pix;
  logic        busy;

  logic [7:0] nt  [2048];
  logic [7:0] pat [2048];

  assign vdata = nt[vaddr];
  assign fdata = pat[faddr];

  always #20 CLK25 = ~CLK25;

  ppu_tile_fetch #(.X_START(XS), .V_LAST(VL)) dut (
    .CLK25 (CLK25),
    .RST   (RST),
    .x     (x),
    .y     (y),
    .vaddr (vaddr),
    .vdata (vdata),
    .faddr (faddr),
    .fdata (fdata),
    .pix   (pix),
    .busy  (busy)
  );

  // Reference model: fk counts cycles since the trigger edge (0 = no fetch).
  int          fk = 0;
  logic [7:0]  mt = '0;
  logic [15:0] m_store [2][32];
  bit          m_valid [2][32];
  logic [10:0] n_vaddr = '0, n_faddr = '0, e_vaddr = '0, e_faddr = '0;
  logic        n_busy = 1'b0, e_busy = 1'b0;
  logic [1:0]  n_pix = '0, e_pix = '0;
  bit          n_known = 1'b1, e_known = 1'b1;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)", name, act, exp, x, y, $time);
    end
  endtask

  function automatic logic [10:0] nt_addr(input int col);
    return {1'b0, mt[7:3], 5'(col)};
  endfunction

  function automatic logic [10:0] pat_addr(input int col, input bit plane);
    logic [7:0] ti;
    ti = nt[nt_addr(col)];
    return {ti[6:0], plane, mt[2:0]};
  endfunction

  task automatic model_reset();
    fk = 0;
    n_vaddr = '0; n_faddr = '0; n_busy = 1'b0; n_pix = '0; n_known = 1'b1;
    e_vaddr = '0; e_faddr = '0; e_busy = 1'b0; e_pix = '0; e_known = 1'b1;
  endtask

  // Compute the outputs expected after the coming clock edge from the
  // current beam position and the fetch progress.
  task automatic model_step();
    int xi, yi, px, bk, b, col, p;
    logic [15:0] e;
    xi = int'(x);
    yi = int'(y);
    if (RST) begin
      model_reset();
      return;
    end
    if (xi >= XS && xi < XS + 512 && yi < 480) begin
      px = (xi - XS) / 2;
      bk = (yi / 2) % 2;
      b  = 7 - (px % 8);
      e  = m_store[bk][px / 8];
      n_pix   = {e[8 + b], e[b]};
      n_known = m_valid[bk][px / 8];
    end else begin
      n_pix   = '0;
      n_known = 1'b1;
    end
    if (fk > 0 && (fk % 4) == 0) begin
      col = fk / 4 - 1;
      m_store[mt[0]][col] = {pat[pat_addr(col, 1'b1)], pat[pat_addr(col, 1'b0)]};
      m_valid[mt[0]][col] = 1'b1;
    end
    if (fk > 0) begin
      fk++;
    end else if (xi == 0 && ((yi < 479 && (yi % 2) == 1) || yi == VL)) begin
      mt = (yi == VL) ? 8'd0 : 8'((yi + 1) / 2);
      fk = 1;
    end
    if (fk > 128) fk = 0;
    n_busy = (fk != 0);
    if (fk != 0) begin
      col = (fk - 1) / 4;
      p   = (fk - 1) % 4;
      n_vaddr = nt_addr(col);
      if (p == 2) n_faddr = pat_addr(col, 1'b0);
      if (p == 3) n_faddr = pat_addr(col, 1'b1);
    end
  endtask

  // One pixel clock with beam at (xv, yv); returns 1 time unit after the edge.
  task automatic cyc(input int xv, input int yv);
    x = 10'(xv);
    y = 10'(yv);
    model_step();
    @(posedge CLK25);
    e_vaddr = n_vaddr; e_faddr = n_faddr; e_busy = n_busy;
    e_pix = n_pix; e_known = n_known;
    #1;
  endtask

  task automatic line(input int yv, input int x0, input int x1);
    for (int xv = x0; xv <= x1; xv++) cyc(xv, yv);
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge CLK25) begin
    if (armed) begin
      chk("busy", int'(busy), int'(e_busy));
      chk("vaddr", int'(vaddr), int'(e_vaddr));
      chk("faddr", int'(faddr), int'(e_faddr));
      if (e_known) chk("pix", int'(pix), int'(e_pix));
    end
  end

  int lit [8] = '{3, 1, 3, 1, 2, 0, 2, 0};

  initial begin
    for (int i = 0; i < 2048; i++) begin
      nt[i]  = 8'h05;
      pat[i] = ((i / 8) % 2 == 1) ? 8'hAA : 8'hF0;
    end
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 32; c++) begin
        m_store[b][c] = '0;
        m_valid[b][c] = 1'b0;
      end
    model_reset();
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK25);
    #1;
    armed = 1'b1;
    chk("rst_pix", int'(pix), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vaddr", int'(vaddr), 0);
    chk("rst_faddr", int'(faddr), 0);
    #4 RST = 1'b0;

    // First fetch (line 1) after reset, fixed tile/pattern data.
    for (int xv = 0; xv < 800; xv++) begin
      cyc(xv, 1);
      if (xv == 0)   begin chk("l1_busy_on", int'(busy), 1); chk("l1_vaddr0", int'(vaddr), 'h000); end
      if (xv == 2)   chk("l1_faddr_lo", int'(faddr), 'h051);
      if (xv == 3)   chk("l1_faddr_hi", int'(faddr), 'h059);
      if (xv == 127) begin chk("l1_busy_last", int'(busy), 1); chk("l1_vaddr31", int'(vaddr), 'h01F); end
      if (xv == 128) chk("l1_busy_off", int'(busy), 0);
    end
    for (int xv = 0; xv < 800; xv++) begin
      cyc(xv, 2);
      if (xv >= 64 && xv <= 79) chk("y2_pix_seq", int'(pix), lit[(xv - 64) / 2]);
    end
    line(3, 0, 799);
    line(4, 0, 600);

    // Trigger while busy is ignored; the running fetch completes on schedule.
    line(5, 0, 40);
    cyc(0, 5);
    chk("retrig_busy", int'(busy), 1);
    chk("retrig_vaddr", int'(vaddr), 'h00A);
    line(5, 1, 86);
    chk("retrig_busy_end", int'(busy), 1);
    cyc(87, 5);
    chk("retrig_idle", int'(busy), 0);
    line(5, 88, 200);

    for (int i = 0; i < 2048; i++) begin
      nt[i]  = 8'($urandom);
      pat[i] = 8'($urandom);
    end

    cyc(0, 523);
    chk("y523_no_fetch", int'(busy), 0);
    line(523, 1, 799);
    for (int xv = 0; xv < 800; xv++) begin
      cyc(xv, VL);
      if (xv == 0)   chk("wrap_vaddr0", int'(vaddr), 'h000);
      if (xv == 2)   chk("wrap_plane_lo", int'(faddr[3]), 0);
      if (xv == 3)   chk("wrap_plane_hi", int'(faddr[3]), 1);
      if (xv == 127) chk("wrap_vaddr31", int'(vaddr), 'h01F);
    end
    line(0, 0, 799);
    line(1, 0, 799);
    line(2, 0, 600);

    // Line 9 lands in bank 1 while bank 0 is displayed.
    cyc(0, 17);
    chk("l9_vaddr_base", int'(vaddr), 'h020);
    cyc(1, 17);
    cyc(2, 17);
    chk("l9_fine_row", int'(faddr[2:0]), 1);
    line(17, 3, 799);
    line(18, 0, 600);

    // Reset in the middle of a fetch.
    line(33, 0, 60);
    #4 RST = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_vaddr", int'(vaddr), 0);
    line(33, 61, 63);
    #4 RST = 1'b0;
    line(33, 64, 799);
    chk("midrst_no_restart", int'(busy), 0);
    line(34, 0, 600);
    for (int xv = 0; xv < 800; xv++) begin
      cyc(xv, 35);
      if (xv == 127) chk("full_after_rst_busy", int'(busy), 1);
      if (xv == 128) chk("full_after_rst_idle", int'(busy), 0);
    end
    for (int xv = 0; xv < 800; xv++) begin
      cyc(xv, 36);
      if (xv == 63)  chk("edge_x63", int'(pix), 0);
      if (xv == 576) chk("edge_x576", int'(pix), 0);
    end
    for (int yv = 480; yv <= 524; yv += 4) begin
      cyc(int'($urandom_range(64, 575)), yv);
      chk("vblank_pix", int'(pix), 0);
    end

    // Randomised line pairs: fetch then display.
    for (int it = 0; it < 25; it++) begin
      int ny;
      ny = int'($urandom_range(1, 239));
      line(2 * ny - 1, 0, 135);
      line(2 * ny, int'($urandom_range(40, 100)), 580);
    end

    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
